// File: rtl/isb_config_tile.sv
// Routing tile: 24-in/24-out interconnect switch block driven by a 72-bit config store
// that is written and read 8 bits at a time over the shared column/row config bus.
module isb_config_tile #(
  parameter int COL_ID  = 0,
  parameter int ROW_GRP = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_WE,
  input  logic        io_RE,
  input  logic [3:0]  io_cAddr,
  input  logic [5:0]  io_rAddr,
  input  logic [3:0]  io_bAddr,
  input  logic [7:0]  io_cDataIn,
  output logic [7:0]  io_cDataOut,
  input  logic [23:0] sb_in,
  output logic [23:0] sb_out
);

  localparam int NumRows = 9;

  logic [71:0] cfg;
  logic        sel;
  logic        rowValid;
  logic [7:0]  rdRow;

  assign sel      = (io_cAddr == 4'(COL_ID)) && (io_rAddr == 6'(ROW_GRP));
  assign rowValid = (io_bAddr <= 4'd8);

  always_comb begin
    rdRow = '0;
    for (int r = 0; r < NumRows; r++) begin
      if (io_bAddr == 4'(r)) rdRow = cfg[8*r +: 8];
    end
  end

  // Readback samples the pre-write row contents, so a same-row RE+WE returns the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg         <= '0;
      io_cDataOut <= '0;
    end else begin
      if (io_WE && sel && rowValid) begin
        for (int r = 0; r < NumRows; r++) begin
          if (io_bAddr == 4'(r)) cfg[8*r +: 8] <= io_cDataIn;
        end
      end
      io_cDataOut <= (io_RE && sel && rowValid) ? rdRow : 8'h00;
    end
  end

  logic n1, n3, n5, n7, n9, n11;
  logic e1, e3, e5, e7, e9, e11;
  logic s0, s2, s4, s6, s8, s10;
  logic w0, w2, w4, w6, w8, w10;

  assign {n11, n9, n7, n5, n3, n1} = sb_in[5:0];
  assign {e11, e9, e7, e5, e3, e1} = sb_in[11:6];
  assign {s10, s8, s6, s4, s2, s0} = sb_in[17:12];
  assign {w10, w8, w6, w4, w2, w0} = sb_in[23:18];

  logic n0, n2, n4, n6, n8, n10;
  logic e0, e2, e4, e6, e8, e10;
  logic s1, s3, s5, s7, s9, s11;
  logic w1, w3, w5, w7, w9, w11;

  // Each output ORs its three gated sources; an open switch masks even an X/Z input to 0.
  assign n0  = (cfg[50] & e3)  | (cfg[58] & s0)  | (cfg[66] & w0);
  assign n2  = (cfg[42] & w10) | (cfg[59] & e5)  | (cfg[67] & s2);
  assign n4  = (cfg[34] & e7)  | (cfg[43] & s4)  | (cfg[51] & w8);
  assign n6  = (cfg[36] & w6)  | (cfg[44] & s6)  | (cfg[52] & e9);
  assign n8  = (cfg[45] & e11) | (cfg[60] & w4)  | (cfg[68] & s8);
  assign n10 = (cfg[53] & w2)  | (cfg[61] & s10) | (cfg[69] & e1);

  assign e0  = (cfg[6]  & s8)  | (cfg[7]  & w0)  | (cfg[14] & n11);
  assign e2  = (cfg[15] & s6)  | (cfg[22] & w2)  | (cfg[23] & n1);
  assign e4  = (cfg[30] & s4)  | (cfg[31] & w4)  | (cfg[38] & n3);
  assign e6  = (cfg[39] & s2)  | (cfg[46] & n5)  | (cfg[47] & w6);
  assign e8  = (cfg[54] & w8)  | (cfg[55] & s0)  | (cfg[63] & n7);
  assign e10 = (cfg[62] & s10) | (cfg[70] & n9)  | (cfg[71] & w10);

  assign s1  = (cfg[2]  & w2)  | (cfg[10] & n1)  | (cfg[18] & e9);
  assign s3  = (cfg[3]  & n3)  | (cfg[11] & e7)  | (cfg[26] & w4);
  assign s5  = (cfg[19] & w6)  | (cfg[27] & n5)  | (cfg[35] & e5);
  assign s7  = (cfg[20] & e3)  | (cfg[28] & n7)  | (cfg[37] & w8);
  assign s9  = (cfg[4]  & n9)  | (cfg[12] & w10) | (cfg[29] & e1);
  assign s11 = (cfg[5]  & e11) | (cfg[13] & n11) | (cfg[21] & w0);

  assign w1  = (cfg[0]  & e1)  | (cfg[1]  & s10) | (cfg[9]  & n1);
  assign w3  = (cfg[8]  & s0)  | (cfg[16] & n11) | (cfg[17] & e3);
  assign w5  = (cfg[24] & e5)  | (cfg[25] & s2)  | (cfg[32] & n9);
  assign w7  = (cfg[33] & s4)  | (cfg[40] & e7)  | (cfg[41] & n7);
  assign w9  = (cfg[48] & s6)  | (cfg[49] & e9)  | (cfg[56] & n5);
  assign w11 = (cfg[57] & s8)  | (cfg[64] & e11) | (cfg[65] & n3);

  assign sb_out = {w11, w9, w7, w5, w3, w1,
                   s11, s9, s7, s5, s3, s1,
                   e10, e8, e6, e4, e2, e0,
                   n10, n8, n6, n4, n2, n0};

endmodule

// File: tb/tb_isb_config_tile.sv
// Directed bench for isb_config_tile: config write/readback, decode gating and the full
// 72-switch map swept one switch at a time against a hand-built switch table.
module tb_isb_config_tile;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_WE;
  logic        io_RE;
  logic [3:0]  io_cAddr;
  logic [5:0]  io_rAddr;
  logic [3:0]  io_bAddr;
  logic [7:0]  io_cDataIn;
  logic [7:0]  io_cDataOut;
  logic [23:0] sb_in;
  logic [23:0] sb_out;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Switch k joins input index inIdx[k] to output index outIdx[k] (bit positions of sb_in/sb_out).
  int inIdx [72] = '{ 6,17,19, 1, 4,11,16,18,12, 0,
                      0, 9,23, 5, 5,15, 5, 7,10,21,
                      7,18,19, 0, 8,13,20, 2, 3, 6,
                     14,20, 4,14, 9, 8,21,22, 1,13,
                      9, 3,23,14,15,11, 2,21,15,10,
                      7,22,10,19,22,12, 2,16,12, 8,
                     20,17,17, 3,11, 1,18,13,16, 6,
                      4,23};
  int outIdx [72] = '{18,18,12,13,16,17, 6, 6,19,18,
                      12,13,16,17, 6, 7,19,19,12,14,
                      15,17, 7, 7,20,20,13,14,15,16,
                       8, 8,20,21, 2,14, 3,15, 8, 9,
                      21,21, 1, 2, 3, 4, 9, 9,22,22,
                       0, 2, 3, 5,10,10,22,23, 0, 1,
                       4, 5,11,10,23,23, 0, 1, 4, 5,
                      11,11};

  isb_config_tile #(.COL_ID(0), .ROW_GRP(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_WE      (io_WE),
    .io_RE      (io_RE),
    .io_cAddr   (io_cAddr),
    .io_rAddr   (io_rAddr),
    .io_bAddr   (io_bAddr),
    .io_cDataIn (io_cDataIn),
    .io_cDataOut(io_cDataOut),
    .sb_in      (sb_in),
    .sb_out     (sb_out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [23:0] v);
    sb_in = v;
    #1;
  endtask

  task automatic writeRow(input logic [3:0] row, input logic [7:0] data);
    io_WE      = 1'b1;
    io_bAddr   = row;
    io_cDataIn = data;
    @(posedge clock);
    #1;
    io_WE = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] row, input logic [7:0] expected);
    io_RE    = 1'b1;
    io_bAddr = row;
    @(posedge clock);
    #1;
    io_RE = 1'b0;
    checkOutput(tag, 32'(io_cDataOut), 32'(expected));
  endtask

  task automatic clearAll();
    for (int r = 0; r < 9; r++) writeRow(4'(r), 8'h00);
  endtask

  initial begin
    reset      = 1'b1;
    io_WE      = 1'b0;
    io_RE      = 1'b0;
    io_cAddr   = 4'd0;
    io_rAddr   = 6'd0;
    io_bAddr   = 4'd0;
    io_cDataIn = 8'h00;
    applyStimulus(24'hFFFFFF);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_sbOut", 32'(sb_out), 32'h0);
    checkOutput("reset_cDataOut", 32'(io_cDataOut), 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("postReset_sbOut", 32'(sb_out), 32'h0);

    // One switch closed at a time: its own input must drive only its output,
    // and every other input driven high must not leak anywhere.
    for (int k = 0; k < 72; k++) begin
      for (int r = 0; r < 9; r++)
        writeRow(4'(r), (r == k / 8) ? 8'(1 << (k % 8)) : 8'h00);
      applyStimulus(24'(1) << inIdx[k]);
      checkOutput($sformatf("sweep%0d_on", k), 32'(sb_out), 32'(24'(1) << outIdx[k]));
      applyStimulus(~(24'(1) << inIdx[k]));
      checkOutput($sformatf("sweep%0d_off", k), 32'(sb_out), 32'h0);
    end
    clearAll();
    applyStimulus(24'h0);

    writeRow(4'd3, 8'hA5);
    readCheck("read_row3", 4'd3, 8'hA5);
    readCheck("read_row4", 4'd4, 8'h00);
    io_cAddr = 4'd1;
    readCheck("read_notSel", 4'd3, 8'h00);
    io_cAddr = 4'd0;
    readCheck("read_bAddr9", 4'd9, 8'h00);

    // Same-row RE+WE returns the old contents; the new value follows.
    io_RE      = 1'b1;
    io_WE      = 1'b1;
    io_bAddr   = 4'd3;
    io_cDataIn = 8'h5A;
    @(posedge clock);
    #1;
    io_RE = 1'b0;
    io_WE = 1'b0;
    checkOutput("rw_sameRow_old", 32'(io_cDataOut), 32'hA5);
    readCheck("rw_sameRow_new", 4'd3, 8'h5A);
    clearAll();

    io_cAddr = 4'd1;
    writeRow(4'd2, 8'hFF);
    io_cAddr = 4'd0;
    io_rAddr = 6'd5;
    writeRow(4'd5, 8'hFF);
    io_rAddr = 6'd0;
    writeRow(4'd9, 8'hFF);
    writeRow(4'd15, 8'hFF);
    for (int r = 0; r < 9; r++) readCheck($sformatf("ignored_row%0d", r), 4'(r), 8'h00);

    // Bits 0,1,9 all feed W1; only the S10 path (bit 1) is active here.
    writeRow(4'd0, 8'h03);
    writeRow(4'd1, 8'h02);
    applyStimulus(24'(1) << 17);
    checkOutput("w1_viaS10", 32'(sb_out), 32'(24'(1) << 18));
    writeRow(4'd0, 8'h01);
    checkOutput("w1_bit1Cleared", 32'(sb_out), 32'h0);
    applyStimulus(24'(1) << 6);
    checkOutput("w1_viaE1", 32'(sb_out), 32'(24'(1) << 18));

    // Reset must win over a coincident write.
    writeRow(4'd3, 8'hA5);
    reset      = 1'b1;
    io_WE      = 1'b1;
    io_bAddr   = 4'd4;
    io_cDataIn = 8'hFF;
    @(posedge clock);
    #1;
    io_WE = 1'b0;
    reset = 1'b0;
    applyStimulus(24'hFFFFFF);
    checkOutput("finalReset_sbOut", 32'(sb_out), 32'h0);
    for (int r = 0; r < 9; r++) readCheck($sformatf("finalReset_row%0d", r), 4'(r), 8'h00);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
